// File: rtl/jtframe_dump_pkg.sv
// Shared state codes, channel modes and the activation rule for the dump trigger.
// Keeping the activation rule here lets every channel evaluate its trigger the same way.
package jtframe_dump_pkg;

   typedef logic [1:0] dump_state_t;

   localparam dump_state_t ST_IDLE   = 2'd0;
   localparam dump_state_t ST_ARMED  = 2'd1;
   localparam dump_state_t ST_ACTIVE = 2'd2;
   localparam dump_state_t ST_DONE   = 2'd3;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_FRAME = 2'd1;
   localparam logic [1:0] MODE_DWNLD = 2'd2;
   localparam logic [1:0] MODE_IMM   = 2'd3;

   // start_hit already includes the frame edge qualifier
   function automatic logic arm_fire(input logic [1:0] mode,
                                     input logic       dedge,
                                     input logic       start_hit);
      return (mode == MODE_IMM)
          || (mode == MODE_DWNLD && dedge)
          || (mode == MODE_FRAME && start_hit);
   endfunction

endpackage

// File: rtl/jtframe_dump_ch.sv
// One capture-window channel: trigger FSM, remaining-frame down-counter and
// registered open/close/done indications.
//
//  state     | meaning
//  ----------+-------------------------------------------------
//  ST_IDLE   | channel disabled (mode off)
//  ST_ARMED  | waiting for its trigger (start frame, download end, immediate)
//  ST_ACTIVE | window open, rem counts frames left (0 = unbounded)
//  ST_DONE   | window closed, waits for rearm
module jtframe_dump_ch
   import jtframe_dump_pkg::*;
#(
   parameter int FW = 16,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fedge_i,
   input  logic          dedge_i,
   input  logic          rearm_i,
   input  logic [1:0]    mode_i,
   input  logic [FW-1:0] start_i,
   input  logic [FW-1:0] nxt_i,
   input  logic [LW-1:0] len_i,
   output logic          en_nxt_o,
   output logic          dump_en_o,
   output logic          dump_on_o,
   output logic          dump_off_o,
   output logic          done_o
);

   dump_state_t   state_q, state_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          on_q, on_d;
   logic          off_q, off_d;
   logic          en_q, done_q;
   logic          start_hit;

   assign start_hit = fedge_i && (start_i != '0) && (nxt_i == start_i);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      on_d    = 1'b0;
      off_d   = 1'b0;
      if (mode_i == MODE_OFF) begin
         state_d = ST_IDLE;
         off_d   = (state_q == ST_ACTIVE);
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if (arm_fire(mode_i, dedge_i, start_hit)) begin
                  state_d = ST_ACTIVE;
                  rem_d   = len_i;
                  on_d    = 1'b1;
               end
            end
            ST_ACTIVE: begin
               // rem stays at zero for an unbounded window
               if (fedge_i && rem_q != '0) begin
                  rem_d = rem_q - 1'b1;
                  if (rem_q == LW'(1)) begin
                     state_d = ST_DONE;
                     off_d   = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (rearm_i) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         on_q    <= 1'b0;
         off_q   <= 1'b0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         on_q    <= on_d;
         off_q   <= off_d;
         en_q    <= (state_d == ST_ACTIVE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign en_nxt_o   = (state_d == ST_ACTIVE);
   assign dump_en_o  = en_q;
   assign dump_on_o  = on_q;
   assign dump_off_o = off_q;
   assign done_o     = done_q;

endmodule

// File: rtl/jtframe_dump_trigger.sv
// Multi-channel capture-window generator: frame counter from VS falling edges,
// download-end detector and one trigger channel per dump enable.
module jtframe_dump_trigger
   import jtframe_dump_pkg::*;
#(
   parameter int NCH = 2,
   parameter int FW  = 16,
   parameter int LW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vs,
   input  logic              dwnld,
   input  logic              rearm,
   input  logic [2*NCH-1:0]  ch_mode,
   input  logic [FW*NCH-1:0] ch_start,
   input  logic [LW*NCH-1:0] ch_len,
   output logic [FW-1:0]     frame_cnt,
   output logic [NCH-1:0]    dump_en,
   output logic [NCH-1:0]    dump_on,
   output logic [NCH-1:0]    dump_off,
   output logic [NCH-1:0]    done,
   output logic              any_en
);

   logic           vs_l_q, dwnld_l_q;
   logic [FW-1:0]  frame_q, nxt;
   logic           any_q;
   logic           fedge, dedge;
   logic [NCH-1:0] en_nxt;

   assign fedge = vs_l_q & ~vs;
   assign dedge = dwnld_l_q & ~dwnld;
   // saturating: the counter sticks at all-ones instead of wrapping
   assign nxt   = (&frame_q) ? frame_q : frame_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_l_q    <= 1'b1;
         dwnld_l_q <= 1'b0;
         frame_q   <= '0;
         any_q     <= 1'b0;
      end else begin
         vs_l_q    <= vs;
         dwnld_l_q <= dwnld;
         if (fedge) frame_q <= nxt;
         any_q     <= |en_nxt;
      end
   end

   assign frame_cnt = frame_q;
   assign any_en    = any_q;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      jtframe_dump_ch #(
         .FW (FW),
         .LW (LW)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .fedge_i    (fedge),
         .dedge_i    (dedge),
         .rearm_i    (rearm),
         .mode_i     (ch_mode[2*c +: 2]),
         .start_i    (ch_start[FW*c +: FW]),
         .nxt_i      (nxt),
         .len_i      (ch_len[LW*c +: LW]),
         .en_nxt_o   (en_nxt[c]),
         .dump_en_o  (dump_en[c]),
         .dump_on_o  (dump_on[c]),
         .dump_off_o (dump_off[c]),
         .done_o     (done[c])
      );
   end

endmodule
